// File: rtl/peak_burst_gen_pkg.sv
// Shared definitions for the peak burst generator: FSM state encoding and
// the helper used to size counters.
package peak_burst_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEAK = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of bits needed to hold values 0..n-1; callers pass N+1 to hold 0..N.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/peak_burst_gen.sv
// Emits bursts of NUM_PEAKS saturating ramp peaks, each followed by GAP_LEN
// zero samples, on an AXI-stream style output with registered outputs.
module peak_burst_gen
  import peak_burst_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PEAKS  = 8,
  parameter int GAP_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base_level,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  input  logic                  out_tready,
  output logic                  peak_stb,
  output logic                  busy,
  output logic                  done,
  output state_t                fsm_state
);

  // Handshake: a beat transfers on a rising edge where out_tvalid and
  // out_tready are both high; while valid is high and ready is low the
  // state, counters and every output hold unchanged.

  localparam int K_W = clog2(NUM_PEAKS + 1);
  localparam int G_W = clog2(GAP_LEN + 1);
  localparam logic [K_W-1:0] K_LAST   = K_W'(NUM_PEAKS - 1);
  localparam logic [G_W-1:0] GAP_LAST = G_W'(GAP_LEN - 1);

  state_t                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [G_W-1:0]        gap_q, gap_d;
  logic [DATA_WIDTH:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;

  logic [DATA_WIDTH-1:0] tdata_d;
  logic                  tvalid_d, tlast_d, stb_d, busy_d, done_d;

  // State, counters, accumulator and output registers
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= IDLE;
      k_q        <= '0;
      gap_q      <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      peak_stb   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      gap_q      <= gap_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      out_tdata  <= tdata_d;
      out_tvalid <= tvalid_d;
      out_tlast  <= tlast_d;
      peak_stb   <= stb_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gap_d   = gap_q;
    acc_d   = acc_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PEAK;
          acc_d   = {1'b0, base_level};
          step_d  = step;
          k_d     = '0;
          gap_d   = '0;
        end
      end
      PEAK: begin
        if (out_tready) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (out_tready) begin
          if (gap_q == GAP_LAST) begin
            if (k_q != K_LAST) begin
              k_d = k_q + 1'b1;
              // The carry bit marks saturation; once set the accumulator freezes.
              acc_d   = acc_q[DATA_WIDTH] ? acc_q : acc_q + {1'b0, step_q};
              state_d = PEAK;
            end else begin
              state_d = DONE;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers
  // aligned with the state they describe.
  always_comb begin
    tvalid_d = (state_d == PEAK) || (state_d == GAP);
    stb_d    = (state_d == PEAK);
    tdata_d  = '0;
    if (state_d == PEAK)
      tdata_d = acc_d[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : acc_d[DATA_WIDTH-1:0];
    tlast_d  = (state_d == GAP) && (gap_d == GAP_LAST) && (k_d == K_LAST);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_peak_burst_gen.sv
// Directed bench for peak_burst_gen: default-parameter bursts with steady and
// random ready, restart and clear during a burst, plus a 1-peak/1-gap instance.
module tb_peak_burst_gen;

  logic        clk = 1'b0;
  logic        reset, clear, start, out_tready;
  logic [15:0] base_level, step, out_tdata;
  logic        out_tvalid, out_tlast, peak_stb, busy, done;
  logic [1:0]  fsm_state;

  logic        s_clear, s_start, s_ready;
  logic [15:0] s_base, s_step, s_tdata;
  logic        s_tvalid, s_tlast, s_stb, s_busy, s_done;
  logic [1:0]  s_state;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];
  logic [15:0] exp_pk[8];

  always #5 clk = ~clk;

  peak_burst_gen u_dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .base_level(base_level), .step(step),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready), .peak_stb(peak_stb), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  peak_burst_gen #(.DATA_WIDTH(16), .NUM_PEAKS(1), .GAP_LEN(1)) u_small (
    .clk(clk), .reset(reset), .clear(s_clear), .start(s_start),
    .base_level(s_base), .step(s_step),
    .out_tdata(s_tdata), .out_tvalid(s_tvalid), .out_tlast(s_tlast),
    .out_tready(s_ready), .peak_stb(s_stb), .busy(s_busy), .done(s_done),
    .fsm_state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats as {peak_stb, tlast, tdata}: a peak then 16 zero gaps, tlast on the very last.
  task automatic fill_q();
    exp_q.delete();
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({1'b1, 1'b0, exp_pk[p]});
      for (int g = 0; g < 16; g++)
        exp_q.push_back({1'b0, (p == 7 && g == 15), 16'h0000});
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic do_burst(input logic [15:0] b, input logic [15:0] s, input bit rnd,
                          input int start_at, input int clear_at);
    logic [17:0] obs, held;
    bit stalled, aborted;
    int beat, cyc;
    base_level = b; step = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_level = 16'h0; step = 16'h0;
    chk("latency_valid", {31'b0, out_tvalid}, 1);
    chk("busy_at_start", {31'b0, busy}, 1);
    stalled = 0; aborted = 0; beat = 0; cyc = 0;
    while (beat < 136 && cyc < 3000) begin
      obs = {peak_stb, out_tlast, out_tdata};
      start = 1'b0;
      if (stalled) chk($sformatf("stall_hold_b%0d", beat), {14'b0, obs}, {14'b0, held});
      chk($sformatf("valid_b%0d", beat), {31'b0, out_tvalid}, 1);
      if (beat == clear_at) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        aborted = 1;
        break;
      end
      if (beat == start_at) begin
        start = 1'b1; base_level = 16'h1111; step = 16'h2222;
        chk("busy_on_restart", {31'b0, busy}, 1);
      end
      out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_tready) begin
        chk($sformatf("beat%0d", beat), {14'b0, obs}, {14'b0, exp_q.pop_front()});
        beat++;
        stalled = 0;
      end else begin
        held = obs;
        stalled = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_tready = 1'b1;
    if (aborted) begin
      chk("abort_valid", {31'b0, out_tvalid}, 0);
      chk("abort_tlast", {31'b0, out_tlast}, 0);
      chk("abort_done", {31'b0, done}, 0);
      chk("abort_busy", {31'b0, busy}, 0);
      @(negedge clk);
      chk("abort_no_done_later", {31'b0, done}, 0);
      exp_q.delete();
    end else begin
      chk("beat_count", beat, 136);
      if (!rnd) chk("no_bubbles", cyc, 136);
      chk("done_pulse", {31'b0, done}, 1);
      chk("valid_in_done", {31'b0, out_tvalid}, 0);
      chk("busy_in_done", {31'b0, busy}, 1);
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 0);
      chk("idle_busy", {31'b0, busy}, 0);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0; out_tready = 1'b1;
    base_level = 16'h0; step = 16'h0;
    s_clear = 1'b0; s_start = 1'b0; s_ready = 1'b1; s_base = 16'h0; s_step = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_state", {30'b0, fsm_state}, 0);
    chk("rst_valid", {31'b0, out_tvalid}, 0);
    chk("rst_data", {16'b0, out_tdata}, 0);
    chk("rst_flags", {28'b0, out_tlast, peak_stb, busy, done}, 0);
    reset = 1'b0;
    @(negedge clk);

    exp_pk = '{16'd100, 16'd150, 16'd200, 16'd250, 16'd300, 16'd350, 16'd400, 16'd450};
    fill_q();
    do_burst(16'd100, 16'd50, 0, -1, -1);

    exp_pk = '{16'hFF00, 16'hFF80, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    fill_q();
    do_burst(16'hFF00, 16'h0080, 0, -1, -1);

    exp_pk = '{16'd100, 16'd150, 16'd200, 16'd250, 16'd300, 16'd350, 16'd400, 16'd450};
    fill_q();
    do_burst(16'd100, 16'd50, 1, -1, -1);

    fill_q();
    do_burst(16'd100, 16'd50, 0, 40, -1);

    fill_q();
    do_burst(16'd100, 16'd50, 0, -1, 60);
    fill_q();
    do_burst(16'd100, 16'd50, 0, -1, -1);

    // clear wins over a simultaneous start
    start = 1'b1; clear = 1'b1; base_level = 16'd7; step = 16'd1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    chk("clear_over_start_valid", {31'b0, out_tvalid}, 0);
    chk("clear_over_start_busy", {31'b0, busy}, 0);

    // 1 peak, 1 gap: two beats
    s_base = 16'h1234; s_step = 16'h0007; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("small_peak", {14'b0, s_stb, s_tlast, s_tdata}, {14'b0, 1'b1, 1'b0, 16'h1234});
    chk("small_peak_valid", {31'b0, s_tvalid}, 1);
    @(negedge clk);
    chk("small_gap", {14'b0, s_stb, s_tlast, s_tdata}, {14'b0, 1'b0, 1'b1, 16'h0000});
    chk("small_gap_valid", {31'b0, s_tvalid}, 1);
    @(negedge clk);
    chk("small_done", {29'b0, s_tvalid, s_done, s_busy}, {29'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("small_idle", {29'b0, s_tvalid, s_done, s_busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peak_burst_gen.md
PEAK_BURST_GEN -- requirements
Module: peak_burst_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width in bits.
REQ-002 Parameter NUM_PEAKS, default 8: peaks per burst; legal range 1..255.
REQ-003 Parameter GAP_LEN, default 16: gap samples after each peak; legal range 1..255.
REQ-004 Port clk  input  1  clock; all logic rising-edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port clear  input  1  synchronous abort; same effect as reset.
REQ-007 Port start  input  1  single-cycle burst request.
REQ-008 Port base_level  input  DATA_WIDTH  unsigned level for peak 0, sampled on accepted start.
REQ-009 Port step  input  DATA_WIDTH  unsigned increment per peak, sampled on accepted start.
REQ-010 Port out_tdata  output  DATA_WIDTH  sample.
REQ-011 Port out_tvalid  output  1  AXI-stream valid.
REQ-012 Port out_tlast  output  1  last beat of burst.
REQ-013 Port out_tready  input  1  AXI-stream ready.
REQ-014 Port peak_stb  output  1  high with out_tvalid on every peak beat.
REQ-015 Port busy  output  1  burst in progress.
REQ-016 Port done  output  1  one-cycle pulse after final beat is accepted.

Function
REQ-017 States SHALL be IDLE, PEAK, GAP, DONE.
REQ-018 IDLE: outputs low; start=1 SHALL latch base_level/step, set peak index k=0, and enter PEAK on the next edge.
REQ-019 start SHALL be ignored when busy=1.
REQ-020 busy SHALL be 1 in PEAK, GAP and DONE, 0 in IDLE.
REQ-021 PEAK: out_tvalid=1, peak_stb=1, out_tdata=min(base+k*step, 2^DATA_WIDTH-1); the value SHALL be computed by a DATA_WIDTH+1-bit running accumulator with saturation.
REQ-022 Once saturated, all later peaks in the burst SHALL remain at all-ones.
REQ-023 On accepted PEAK beat: gap counter cleared, go to GAP.
REQ-024 GAP: out_tvalid=1, peak_stb=0, out_tdata=0; each accepted beat increments the gap counter.
REQ-025 On the GAP_LEN-th accepted gap beat: if k<NUM_PEAKS-1, increment k, add step to the accumulator, and go to PEAK; else go to DONE.
REQ-026 out_tlast SHALL be 1 only on the final gap beat of peak NUM_PEAKS-1.
REQ-027 Burst length SHALL be exactly NUM_PEAKS*(1+GAP_LEN) beats.
REQ-028 DONE: out_tvalid=0, done=1 for one cycle, then IDLE; a new start is accepted no earlier than the following cycle.
REQ-029 While out_tvalid=1 and out_tready=0, out_tdata, out_tlast and peak_stb SHALL hold stable, with no state advance.
REQ-030 With out_tready held high, the block SHALL deliver one beat per cycle with no bubbles between PEAK and GAP.
REQ-031 First out_tvalid SHALL assert on the cycle after the start cycle, i.e. latency 1.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On reset or clear: state=IDLE, out_tvalid=0, out_tlast=0, peak_stb=0, busy=0, done=0, out_tdata=0, counters and accumulator zero.
REQ-034 A clear or reset mid-burst SHALL abort on the next edge, with no tlast or done emitted.
REQ-035 clear SHALL take priority over start in the same cycle.

Structure
REQ-036 Shared package SHALL hold the state encoding (IDLE=0, PEAK=1, GAP=2, DONE=3) and the counter width function clog2(N+1).
REQ-037 Single flat module; no sub-module required.

Verification
REQ-038 Defaults, base=100, step=50, ready=1 -> 136 beats; peaks 100,150,...,450 at beats 0,17,...,119; peak_stb on those 8 beats only; tlast on beat 135; done one cycle later.
REQ-039 base=0xFF00, step=0x0080 -> peaks FF00, FF80, then FFFF for peaks 2..7.
REQ-040 Random out_tready at 50% -> beat sequence identical to REQ-038; tdata/tlast/peak_stb stable while stalled.
REQ-041 start pulsed at beat 40 of a burst -> ignored; burst unchanged; busy stays 1.
REQ-042 clear at beat 60 -> out_tvalid=0 next cycle, no tlast, no done; a new start then gives a full 136-beat burst.
REQ-043 NUM_PEAKS=1, GAP_LEN=1 -> 2 beats: peak=base with peak_stb, then 0 with tlast.
